// File: rtl/acc_reduce_block.sv
// acc_reduce_block: lane-sum / vector-accumulate tile.
// Each beat's LANES signed lanes are summed, the sums are accumulated over a
// runtime vector length, and the saturated (optionally ReLU'd) result is
// broadcast on every lane. Each neighbour port carries either that result or
// the registered input beat.
module acc_reduce_block #(
    parameter int LANES   = 4,
    parameter int DW      = 32,
    parameter int MAX_LEN = 1024,
    parameter int CNT_W   = 11,
    parameter int ACC_W   = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stage_start,
    input  logic                  block_en,
    input  logic [1:0]            output_sel,
    input  logic                  relu_en,
    input  logic [CNT_W-1:0]      vec_len,
    input  logic                  in_valid,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  west_out_valid,
    output logic [LANES*DW-1:0]   west_out_data,
    output logic                  south_out_valid,
    output logic [LANES*DW-1:0]   south_out_data,
    output logic                  ovf
);

    localparam logic [CNT_W-1:0]        LEN_ONE = CNT_W'(1);
    // Lengths above MAX_LEN are clamped: the accumulator is only sized for MAX_LEN beats.
    localparam logic [CNT_W-1:0]        LEN_MAX = CNT_W'(MAX_LEN);
    localparam logic signed [DW-1:0]    RES_HI  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]    RES_LO  = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_HI  = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_LO  = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Clamp the accumulator into the lane range; MSB of the return is the overflow flag.
    function automatic logic [DW:0] sat_acc(input logic signed [ACC_W-1:0] a);
        if (a > ACC_HI) begin
            return {1'b1, RES_HI};
        end else if (a < ACC_LO) begin
            return {1'b1, RES_LO};
        end else begin
            return {1'b0, a[DW-1:0]};
        end
    endfunction

    // Optional rectifier applied after saturation; it never touches the overflow flag.
    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v,
                                                  input logic en);
        return (en && v[DW-1]) ? '0 : v;
    endfunction

    logic [LANES*DW-1:0]     in_reg_p1;
    logic                    in_vld_p1;
    logic signed [DW-1:0]    lane;
    logic signed [ACC_W-1:0] tree_sum;
    logic signed [ACC_W-1:0] sum_p2;
    logic                    sum_vld_p2;
    logic [CNT_W-1:0]        beat_cnt;
    logic [CNT_W-1:0]        len_reg;
    logic [CNT_W-1:0]        len_cur;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic                    last_beat;
    logic [DW:0]             sat_word;
    logic signed [DW-1:0]    res_next;
    logic signed [DW-1:0]    res_p3;
    logic                    res_ovf_p3;
    logic                    res_vld_p3;

    // ---- stage 1: input register; a low stage_start flushes the beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_reg_p1 <= '0;
            in_vld_p1 <= 1'b0;
        end else if (stage_start) begin
            in_reg_p1 <= in_data;
            in_vld_p1 <= in_valid;
        end else begin
            in_reg_p1 <= '0;
            in_vld_p1 <= 1'b0;
        end
    end

    // Sign-extended sum of all lanes of the registered beat.
    always_comb begin
        tree_sum = '0;
        lane     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane     = in_reg_p1[i*DW +: DW];
            tree_sum = tree_sum + {{(ACC_W-DW){lane[DW-1]}}, lane};
        end
    end

    // ---- stage 2: lane-sum register; only beats seen in reduce mode are valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p2     <= '0;
            sum_vld_p2 <= 1'b0;
        end else begin
            sum_p2     <= tree_sum;
            sum_vld_p2 <= stage_start & in_vld_p1 & block_en;
        end
    end

    // Vector length is taken from vec_len on the first beat and held for the rest.
    always_comb begin
        if (beat_cnt == '0) begin
            if (vec_len == '0) begin
                len_cur = LEN_ONE;
            end else if (vec_len > LEN_MAX) begin
                len_cur = LEN_MAX;
            end else begin
                len_cur = vec_len;
            end
            acc_next = sum_p2;
        end else begin
            len_cur  = len_reg;
            acc_next = acc + sum_p2;
        end
        last_beat = (beat_cnt == (len_cur - LEN_ONE));
        sat_word  = sat_acc(acc_next);
        res_next  = relu(sat_word[DW-1:0], relu_en);
    end

    // ---- stage 3: accumulate over the vector and emit a one-cycle result pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            len_reg    <= '0;
            acc        <= '0;
            res_p3     <= '0;
            res_ovf_p3 <= 1'b0;
            res_vld_p3 <= 1'b0;
        end else if (!stage_start) begin
            beat_cnt   <= '0;
            acc        <= '0;
            res_vld_p3 <= 1'b0;
        end else begin
            res_vld_p3 <= 1'b0;
            if (sum_vld_p2) begin
                acc <= acc_next;
                if (beat_cnt == '0) begin
                    len_reg <= len_cur;
                end
                if (last_beat) begin
                    res_vld_p3 <= 1'b1;
                    res_p3     <= res_next;
                    res_ovf_p3 <= sat_word[DW];
                    beat_cnt   <= '0;
                end else begin
                    beat_cnt <= beat_cnt + LEN_ONE;
                end
            end
        end
    end

    // ---- stage 4: steer result or registered input to each neighbour port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            west_out_valid  <= 1'b0;
            west_out_data   <= '0;
            south_out_valid <= 1'b0;
            south_out_data  <= '0;
            ovf             <= 1'b0;
        end else begin
            if (stage_start && block_en) begin
                west_out_valid  <= output_sel[0] ? res_vld_p3 : in_vld_p1;
                west_out_data   <= output_sel[0] ? {LANES{res_p3}} : in_reg_p1;
                south_out_valid <= output_sel[1] ? res_vld_p3 : in_vld_p1;
                south_out_data  <= output_sel[1] ? {LANES{res_p3}} : in_reg_p1;
            end else if (stage_start) begin
                west_out_valid  <= in_vld_p1;
                west_out_data   <= in_reg_p1;
                south_out_valid <= in_vld_p1;
                south_out_data  <= in_reg_p1;
            end else begin
                west_out_valid  <= 1'b0;
                west_out_data   <= '0;
                south_out_valid <= 1'b0;
                south_out_data  <= '0;
            end
            ovf <= res_vld_p3 & res_ovf_p3;
        end
    end

endmodule

// File: tb/tb_acc_reduce_block.sv
// Testbench for acc_reduce_block: scoreboard of expected port beats, results
// and overflow pulses, each tagged with the cycle it must appear in.
module tb_acc_reduce_block;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int CNT_W = 11;
    localparam int W     = LANES * DW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stage_start = 1'b0;
    logic             block_en = 1'b0;
    logic [1:0]       output_sel = 2'b00;
    logic             relu_en = 1'b0;
    logic [CNT_W-1:0] vec_len = '0;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             west_out_valid;
    logic [W-1:0]     west_out_data;
    logic             south_out_valid;
    logic [W-1:0]     south_out_data;
    logic             ovf;

    acc_reduce_block #(.LANES(LANES), .DW(DW), .MAX_LEN(1024), .CNT_W(CNT_W), .ACC_W(48)) dut (
        .clk(clk), .rst(rst), .stage_start(stage_start), .block_en(block_en),
        .output_sel(output_sel), .relu_en(relu_en), .vec_len(vec_len),
        .in_valid(in_valid), .in_data(in_data),
        .west_out_valid(west_out_valid), .west_out_data(west_out_data),
        .south_out_valid(south_out_valid), .south_out_data(south_out_data),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
    } exp_t;

    exp_t wq[$];
    exp_t sq[$];
    int   oq[$];
    int   checks = 0;
    int   failures = 0;

    int     m_cnt = 0;
    int     m_len = 1;
    longint m_acc = 0;

    function automatic logic [W-1:0] bcast(input logic [DW-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] fill4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic longint lane_sum(input logic [W-1:0] d);
        longint s = 0;
        for (int i = 0; i < LANES; i++) s += longint'($signed(d[i*DW +: DW]));
        return s;
    endfunction

    // Drive one cycle of input and push whatever the ports must show for it.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic [CNT_W-1:0] len);
        exp_t        e;
        longint      r;
        logic        ov;
        logic [63:0] rb;
        longint      hi;
        longint      lo;
        hi = (longint'(1) <<< 31) - 1;
        lo = -(longint'(1) <<< 31);
        @(posedge clk); #1;
        in_valid = v;
        in_data  = d;
        vec_len  = len;
        if (v && stage_start) begin
            e.cyc  = cyc + 2;
            e.data = d;
            if (!block_en || !output_sel[0]) wq.push_back(e);
            if (!block_en || !output_sel[1]) sq.push_back(e);
            if (block_en) begin
                if (m_cnt == 0) begin
                    m_len = (len == 0) ? 1 : int'(len);
                    m_acc = lane_sum(d);
                end else begin
                    m_acc += lane_sum(d);
                end
                if (m_cnt == m_len - 1) begin
                    r  = m_acc;
                    ov = 1'b0;
                    if (r > hi) begin r = hi; ov = 1'b1; end
                    else if (r < lo) begin r = lo; ov = 1'b1; end
                    if (relu_en && r < 0) r = 0;
                    rb     = r;
                    e.cyc  = cyc + 4;
                    e.data = bcast(rb[DW-1:0]);
                    if (output_sel[0]) wq.push_back(e);
                    if (output_sel[1]) sq.push_back(e);
                    if (ov) oq.push_back(cyc + 4);
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((wq.size() + sq.size() + oq.size()) != 0 && k < 20) begin
            idle(1);
            k++;
        end
        idle(2);
    endtask

    // Scoreboard: every port pulse and overflow pulse must match the queue head.
    exp_t we;
    exp_t se;
    int   oc;
    always @(negedge clk) begin
        if (!rst) begin
            if (west_out_valid) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL west_unexpected: data=%h at cyc %0d, required no output", west_out_data, cyc);
                end else begin
                    we = wq.pop_front();
                    if (west_out_data !== we.data || cyc != we.cyc) begin
                        failures++;
                        $display("FAIL west_beat: got %h at cyc %0d, required %h at cyc %0d", west_out_data, cyc, we.data, we.cyc);
                    end
                end
            end
            if (south_out_valid) begin
                checks++;
                if (sq.size() == 0) begin
                    failures++;
                    $display("FAIL south_unexpected: data=%h at cyc %0d, required no output", south_out_data, cyc);
                end else begin
                    se = sq.pop_front();
                    if (south_out_data !== se.data || cyc != se.cyc) begin
                        failures++;
                        $display("FAIL south_beat: got %h at cyc %0d, required %h at cyc %0d", south_out_data, cyc, se.data, se.cyc);
                    end
                end
            end
            if (ovf) begin
                checks++;
                if (oq.size() == 0) begin
                    failures++;
                    $display("FAIL ovf_unexpected: ovf=1 at cyc %0d, required 0", cyc);
                end else begin
                    oc = oq.pop_front();
                    if (cyc != oc) begin
                        failures++;
                        $display("FAIL ovf_cycle: ovf at cyc %0d, required cyc %0d", cyc, oc);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; stage_start = 1'b1; block_en = 1'b0; in_valid = 1'b1;
        in_data = {4{32'hDEADBEEF}};
        repeat (3) @(posedge clk); #1;
        checks++; if (west_out_valid !== 1'b0) begin failures++; $display("FAIL reset_west_valid: got %b required 0", west_out_valid); end
        checks++; if (west_out_data !== '0) begin failures++; $display("FAIL reset_west_data: got %h required 0", west_out_data); end
        checks++; if (south_out_valid !== 1'b0) begin failures++; $display("FAIL reset_south_valid: got %b required 0", south_out_valid); end
        checks++; if (south_out_data !== '0) begin failures++; $display("FAIL reset_south_data: got %h required 0", south_out_data); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b required 0", ovf); end
        in_valid = 1'b0; stage_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_sum();
        stage_start = 1'b1; block_en = 1'b1; output_sel = 2'b01; relu_en = 1'b0;
        repeat (3) drive(1'b1, fill4(1, 2, 3, 4), 11'd3);
        drain();
        checks++;
        if (wq.size() + sq.size() + oq.size() != 0) begin
            failures++; $display("FAIL sum_drain: pending=%0d required 0", wq.size() + sq.size() + oq.size());
        end
    endtask

    task automatic test_saturation();
        stage_start = 1'b1; block_en = 1'b1; output_sel = 2'b01; relu_en = 1'b0;
        repeat (2) drive(1'b1, bcast(32'h7FFFFFFF), 11'd2);
        drain();
        repeat (2) drive(1'b1, bcast(32'h80000000), 11'd2);
        drain();
        checks++;
        if (wq.size() + sq.size() + oq.size() != 0) begin
            failures++; $display("FAIL sat_drain: pending=%0d required 0", wq.size() + sq.size() + oq.size());
        end
    endtask

    task automatic test_relu();
        stage_start = 1'b1; block_en = 1'b1; output_sel = 2'b01; relu_en = 1'b0;
        drive(1'b1, fill4(-5, -5, -5, -5), 11'd1);
        drain();
        relu_en = 1'b1;
        drive(1'b1, fill4(-5, -5, -5, -5), 11'd1);
        drain();
        relu_en = 1'b0;
        checks++;
        if (wq.size() + sq.size() + oq.size() != 0) begin
            failures++; $display("FAIL relu_drain: pending=%0d required 0", wq.size() + sq.size() + oq.size());
        end
    endtask

    task automatic test_passthrough();
        stage_start = 1'b1; block_en = 1'b0; output_sel = 2'b11;
        for (int i = 0; i < 5; i++) drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 11'd2);
        drain();
        checks++;
        if (wq.size() + sq.size() + oq.size() != 0) begin
            failures++; $display("FAIL pass_drain: pending=%0d required 0", wq.size() + sq.size() + oq.size());
        end
    endtask

    task automatic test_back_to_back();
        stage_start = 1'b1; block_en = 1'b1; output_sel = 2'b01;
        drive(1'b1, fill4(-7, 100, 3, 0), 11'd2);
        drive(1'b0, {4{32'h55AA55AA}}, 11'd2);
        drive(1'b1, fill4(5, 5, 5, 5), 11'd2);
        drive(1'b1, fill4(1000, -1, -2, -3), 11'd1);
        drain();
        checks++;
        if (wq.size() + sq.size() + oq.size() != 0) begin
            failures++; $display("FAIL b2b_drain: pending=%0d required 0", wq.size() + sq.size() + oq.size());
        end
    endtask

    task automatic test_abort();
        stage_start = 1'b1; block_en = 1'b1; output_sel = 2'b01;
        drive(1'b1, fill4(9, 9, 9, 9), 11'd3);
        drive(1'b0, '0, 11'd3);
        @(posedge clk); #1;
        stage_start = 1'b0; in_valid = 1'b0; m_cnt = 0;
        @(posedge clk); #1;
        stage_start = 1'b1;
        drive(1'b1, fill4(1, -2, 3, -4), 11'd3);
        drive(1'b1, fill4(10, 20, 30, 40), 11'd3);
        drive(1'b1, fill4(-100, 0, 0, 7), 11'd3);
        drain();
        checks++;
        if (wq.size() + sq.size() + oq.size() != 0) begin
            failures++; $display("FAIL abort_drain: pending=%0d required 0", wq.size() + sq.size() + oq.size());
        end
    endtask

    task automatic test_async_reset();
        stage_start = 1'b1; block_en = 1'b1; output_sel = 2'b10;
        drive(1'b1, fill4(11, 12, 13, 14), 11'd3);
        drive(1'b1, fill4(21, 22, 23, 24), 11'd3);
        @(posedge clk); #2;
        checks++;
        if (west_out_valid !== 1'b1) begin
            failures++; $display("FAIL arst_pre_valid: got %b required 1", west_out_valid);
        end
        rst = 1'b1; in_valid = 1'b0;
        wq.delete(); sq.delete(); oq.delete();
        #1;
        checks++; if (west_out_valid !== 1'b0) begin failures++; $display("FAIL arst_west_valid: got %b required 0", west_out_valid); end
        checks++; if (west_out_data !== '0) begin failures++; $display("FAIL arst_west_data: got %h required 0", west_out_data); end
        checks++; if (south_out_valid !== 1'b0) begin failures++; $display("FAIL arst_south_valid: got %b required 0", south_out_valid); end
        checks++; if (south_out_data !== '0) begin failures++; $display("FAIL arst_south_data: got %h required 0", south_out_data); end
        @(posedge clk); #1;
        rst = 1'b0; m_cnt = 0;
        drive(1'b1, fill4(3, 4, 5, 6), 11'd2);
        drive(1'b1, fill4(-1, -1, 50, 0), 11'd2);
        drain();
        checks++;
        if (wq.size() + sq.size() + oq.size() != 0) begin
            failures++; $display("FAIL arst_drain: pending=%0d required 0", wq.size() + sq.size() + oq.size());
        end
    endtask

    initial begin
        test_reset();
        test_sum();
        test_saturation();
        test_relu();
        test_passthrough();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
